// File: rtl/fc3_ctrl_pkg.sv
// Shared constants, pipeline latencies and one-hot state encoding for the fc3 layer controller.
package fc3_ctrl_pkg;

  localparam int unsigned N_IN     = 84;
  localparam int unsigned N_OUT    = 10;
  localparam int unsigned RD_LAT   = 2;
  localparam int unsigned MAC_LAT  = 3;
  localparam int unsigned POST_LAT = 1;
  localparam int unsigned DW       = 16;

  // Clear lines up with the first product entering the MAC; write with the bias-added result.
  localparam int unsigned CLR_LAT = RD_LAT + 1;
  localparam int unsigned WR_LAT  = RD_LAT + MAC_LAT + POST_LAT;

  typedef enum logic [2:0] {
    StIdle = 3'b001,
    StRun  = 3'b010,
    StDone = 3'b100
  } fc3_state_e;

endpackage

// File: rtl/fc3_ctrl_pipe_delay.sv
// Fixed-depth shift register used to align control strobes with the datapath pipeline.
module fc3_ctrl_pipe_delay #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage_q [Depth];
  logic [Width-1:0] stage_d [Depth];

  always_comb begin
    stage_d[0] = d_i;
    for (int unsigned i = 1; i < Depth; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < Depth; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q_o = stage_q[Depth-1];

endmodule

// File: rtl/fc3_ctrl.sv
// Final fully-connected layer controller: address generation plus pipeline-aligned strobes.
// Define FC3_ARGMAX_EN to add the running argmax over the ten class scores.
module fc3_ctrl
  import fc3_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          fc3_start,
  input  logic [DW-1:0] fc3_dout,
  output logic [6:0]    f7_raddr,
  output logic [9:0]    w7_raddr,
  output logic          fc3_clr,
  output logic          f8_wr_en,
  output logic [3:0]    f8_waddr,
  output logic          fc3_done,
  output logic [3:0]    class_id,
  output logic          class_valid
);

  localparam logic [6:0] InLast  = 7'(N_IN - 1);
  localparam logic [3:0] OutLast = 4'(N_OUT - 1);

  fc3_state_e state_q, state_d;
  logic [6:0] in_idx_q, in_idx_d;
  logic [3:0] out_idx_q, out_idx_d;
  logic       in_wrap, run;
  logic       clr_t, wr_t, done_t;
  logic [4:0] wr_pipe_in, wr_pipe_out;

  assign in_wrap = (in_idx_q == InLast);

  always_comb begin
    state_d   = state_q;
    in_idx_d  = in_idx_q;
    out_idx_d = out_idx_q;
    run       = 1'b0;
    case (state_q)
      StIdle: begin
        if (fc3_start) state_d = StRun;
      end
      StRun: begin
        run      = 1'b1;
        in_idx_d = in_wrap ? 7'd0 : in_idx_q + 7'd1;
        if (in_wrap) begin
          out_idx_d = (out_idx_q == OutLast) ? 4'd0 : out_idx_q + 4'd1;
          if (out_idx_q == OutLast) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      in_idx_q  <= '0;
      out_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      in_idx_q  <= in_idx_d;
      out_idx_q <= out_idx_d;
    end
  end

  assign f7_raddr = in_idx_q;
  assign w7_raddr = 10'(out_idx_q) * 10'(N_IN) + 10'(in_idx_q);

  assign clr_t  = run && (in_idx_q == 7'd0);
  assign wr_t   = run && in_wrap;
  assign done_t = (state_q == StDone);

  // Address is gated so f8_waddr stays 0 between writes.
  assign wr_pipe_in = {wr_t, wr_t ? out_idx_q : 4'd0};

  fc3_ctrl_pipe_delay #(
    .Width(1),
    .Depth(CLR_LAT)
  ) u_clr_dly (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (clr_t),
    .q_o  (fc3_clr)
  );

  fc3_ctrl_pipe_delay #(
    .Width(5),
    .Depth(WR_LAT)
  ) u_wr_dly (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (wr_pipe_in),
    .q_o  (wr_pipe_out)
  );

  assign f8_wr_en = wr_pipe_out[4];
  assign f8_waddr = wr_pipe_out[3:0];

  fc3_ctrl_pipe_delay #(
    .Width(1),
    .Depth(WR_LAT)
  ) u_done_dly (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (done_t),
    .q_o  (fc3_done)
  );

`ifdef FC3_ARGMAX_EN
  logic signed [DW-1:0] max_q, max_d;
  logic [3:0]           best_q, best_d;
  logic [3:0]           class_q, class_d;

  // Strictly-greater update keeps the lowest index on ties.
  always_comb begin
    max_d   = max_q;
    best_d  = best_q;
    class_d = class_q;
    if (f8_wr_en && ((f8_waddr == 4'd0) || ($signed(fc3_dout) > max_q))) begin
      max_d  = $signed(fc3_dout);
      best_d = f8_waddr;
    end
    if (fc3_done) class_d = best_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q   <= '0;
      best_q  <= '0;
      class_q <= '0;
    end else begin
      max_q   <= max_d;
      best_q  <= best_d;
      class_q <= class_d;
    end
  end

  // The last score lands the cycle before fc3_done, so bypass the holding register then.
  assign class_id    = fc3_done ? best_q : class_q;
  assign class_valid = fc3_done;
`else
  logic unused_dout;
  assign unused_dout = ^fc3_dout;
  assign class_id    = 4'd0;
  assign class_valid = 1'b0;
`endif

endmodule

// File: tb/tb_fc3_ctrl.sv
// Scoreboard bench for fc3_ctrl: stimulus queues expected strobe events, a monitor pops and checks.
module tb_fc3_ctrl;
  import fc3_ctrl_pkg::*;

  localparam int RunLen = N_IN * N_OUT;

  logic          clk = 1'b0;
  logic          rst;
  logic          fc3_start;
  logic [DW-1:0] fc3_dout;
  logic [6:0]    f7_raddr;
  logic [9:0]    w7_raddr;
  logic          fc3_clr;
  logic          f8_wr_en;
  logic [3:0]    f8_waddr;
  logic          fc3_done;
  logic [3:0]    class_id;
  logic          class_valid;

  fc3_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .fc3_start  (fc3_start),
    .fc3_dout   (fc3_dout),
    .f7_raddr   (f7_raddr),
    .w7_raddr   (w7_raddr),
    .fc3_clr    (fc3_clr),
    .f8_wr_en   (f8_wr_en),
    .f8_waddr   (f8_waddr),
    .fc3_done   (fc3_done),
    .class_id   (class_id),
    .class_valid(class_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int v;
  } ev_t;

  ev_t clr_q[$];
  ev_t wr_q[$];
  ev_t done_q[$];
  int  run_start = -1000000;
  int  scores[10];
  int  checks = 0;
  int  errors = 0;
  int  exp_cls = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit fsm_idle(input int c);
    return !(c >= run_start + 1 && c <= run_start + RunLen + 1);
  endfunction

  function automatic int argmax_ref();
    int b = 0;
    for (int k = 1; k < 10; k++) if (scores[k] > scores[b]) b = k;
    return b;
  endfunction

  // A start seen in an idle cycle s yields addresses from s+1, clears at s+4+84k,
  // writes at s+90+84k and done at s+847.
  task automatic try_start();
    fc3_start = 1'b1;
    if (fsm_idle(cyc)) begin
      run_start = cyc;
      for (int k = 0; k < N_OUT; k++) begin
        clr_q.push_back('{cyc + 4 + N_IN * k, 0});
        wr_q.push_back('{cyc + N_IN + 6 + N_IN * k, k});
      end
      done_q.push_back('{cyc + RunLen + 7, argmax_ref()});
    end
    tick();
    fc3_start = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    clr_q.delete();
    wr_q.delete();
    done_q.delete();
    run_start = -1000000;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic rand_scores(input int lo, input int hi);
    for (int k = 0; k < 10; k++) scores[k] = lo + int'($urandom_range(0, hi - lo));
  endtask

  // Present the queued score on write slots, junk elsewhere.
  initial begin
    int rel;
    fc3_dout = '0;
    forever begin
      tick();
      rel = cyc - run_start - (N_IN + 6);
      if (rel >= 0 && rel % N_IN == 0 && rel / N_IN < N_OUT) fc3_dout = DW'(scores[rel / N_IN]);
      else fc3_dout = DW'($urandom);
    end
  end

  initial begin
    int j;
    bit exp_clr, exp_wr, exp_done;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_f7", int'(f7_raddr), 0);
        check("rst_w7", int'(w7_raddr), 0);
        check("rst_clr", int'(fc3_clr), 0);
        check("rst_wr", int'(f8_wr_en), 0);
        check("rst_waddr", int'(f8_waddr), 0);
        check("rst_done", int'(fc3_done), 0);
        check("rst_cls", int'(class_id), 0);
        check("rst_cvalid", int'(class_valid), 0);
        exp_cls = 0;
      end else begin
        j = cyc - run_start - 1;
        if (j >= 0 && j < RunLen) begin
          check("f7_raddr", int'(f7_raddr), j % N_IN);
          check("w7_raddr", int'(w7_raddr), j);
        end else begin
          check("f7_idle", int'(f7_raddr), 0);
          check("w7_idle", int'(w7_raddr), 0);
        end
        exp_clr = clr_q.size() > 0 && clr_q[0].c == cyc;
        check("fc3_clr", int'(fc3_clr), int'(exp_clr));
        if (exp_clr) void'(clr_q.pop_front());
        exp_wr = wr_q.size() > 0 && wr_q[0].c == cyc;
        check("f8_wr_en", int'(f8_wr_en), int'(exp_wr));
        if (exp_wr) begin
          check("f8_waddr", int'(f8_waddr), wr_q[0].v);
          void'(wr_q.pop_front());
        end
        exp_done = done_q.size() > 0 && done_q[0].c == cyc;
        check("fc3_done", int'(fc3_done), int'(exp_done));
        if (exp_done) begin
          exp_cls = done_q[0].v;
          void'(done_q.pop_front());
        end
`ifdef FC3_ARGMAX_EN
        check("class_valid", int'(class_valid), int'(exp_done));
        check("class_id", int'(class_id), exp_cls);
`else
        check("class_valid", int'(class_valid), 0);
        check("class_id", int'(class_id), 0);
`endif
      end
    end
  end

  initial begin
    int s;
    int t;
    rst = 1'b1;
    fc3_start = 1'b0;
    for (int k = 0; k < 10; k++) scores[k] = 0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();

    // Clean run with a tie at the top (indices 2 and 3).
    scores = '{-5, 3, 7, 7, -1, 0, 2, 6, 1, -8};
    try_start();
    while (cyc < run_start + RunLen + 10) tick();

    // All-negative scores, spurious starts in RUN and DONE, then a back-to-back start.
    scores = '{-9, -3, -7, -2, -1, -6, -4, -8, -5, -10};
    try_start();
    s = run_start;
    while (cyc < s + 5) tick();
    try_start();
    while (cyc < s + 400) tick();
    try_start();
    while (cyc < s + RunLen + 1) tick();
    try_start();
    while (cyc < s + RunLen + 7) tick();
    rand_scores(-4, 4);
    try_start();
    s = run_start;
    for (int n = 0; n < 3; n++) begin
      t = cyc + int'($urandom_range(20, 250));
      while (cyc < t) tick();
      try_start();
    end
    while (cyc < s + RunLen + 10) tick();

    // Reset in the middle of a run discards in-flight strobes.
    rand_scores(-1000, 1000);
    try_start();
    s = run_start;
    while (cyc < s + 300) tick();
    do_reset(1);
    repeat (900) tick();

    rand_scores(-30000, 30000);
    try_start();
    while (cyc < run_start + RunLen + 12) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc3_ctrl.md
Name: fc3_ctrl

Overview:
Controller for the final fully-connected layer (84 inputs -> 10 class scores), directly downstream of the fc2 stage.
- Consumes the 84-entry f7 buffer that fc2 writes.
- Generates the f7 feature and w7 weight read addresses.
- Drives the shared MAC accumulator clear, the f8 result write strobe/address and the layer-done pulse, each delayed to match the datapath pipeline.

Parameters:
N_IN, 84, input features per neuron (f7 depth)
N_OUT, 10, output neurons / classes
RD_LAT, 2, address-to-data latency of f7/w7 RAMs
MAC_LAT, 3, MAC pipeline depth
POST_LAT, 1, bias-add stage (no ReLU on this layer)
DW, 16, width of fc3_dout (signed, optional feature only)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
fc3_start  in  1  one-cycle start pulse from fc2_done
fc3_dout  in  DW  signed bias-added result presented alongside f8_wr_en (used only by the optional feature)
f7_raddr  out  7  feature read address, 0..N_IN-1
w7_raddr  out  10  weight read address, out_idx*N_IN + in_idx, 0..839
fc3_clr  out  1  accumulator clear, aligned to first product of each neuron
f8_wr_en  out  1  result write strobe
f8_waddr  out  4  result write address, 0..N_OUT-1
fc3_done  out  1  one-cycle layer-complete pulse
class_id  out  4  argmax class (optional feature)
class_valid  out  1  one-cycle pulse with valid class_id (optional feature)

Behaviour:
- Reset:
  - FSM goes to IDLE; all counters and delay-line stages clear to 0.
  - Every output is 0 during and after reset.
- FSM, one-hot, 3 states:
  - IDLE -> RUN on fc3_start.
  - RUN -> DONE when in_idx==N_IN-1 && out_idx==N_OUT-1.
  - DONE -> IDLE unconditionally.
  - Illegal state -> IDLE.
- fc3_start outside IDLE is ignored.
- Counters:
  - in_idx (7b) increments every RUN cycle and wraps N_IN-1 -> 0.
  - out_idx (4b) increments on in_idx wrap and wraps N_OUT-1 -> 0.
  - Both hold outside RUN.
  - RUN lasts exactly N_IN*N_OUT = 840 cycles.
- Addresses are combinational from the counters:
  - f7_raddr = in_idx.
  - w7_raddr = out_idx*N_IN + in_idx, 10-bit result, no overflow at defaults.
- Undelayed strobes:
  - clr_t = RUN && in_idx==0.
  - wr_t = RUN && in_idx==N_IN-1.
  - done_t = state==DONE.
- Delay lines (shift registers; no reset required beyond the reset above):
  - fc3_clr = clr_t delayed RD_LAT+1 = 3 cycles.
  - f8_wr_en = wr_t delayed WR_LAT = RD_LAT+MAC_LAT+POST_LAT = 6 cycles.
  - f8_waddr = out_idx sampled with wr_t, delayed the same 6 cycles.
  - fc3_done = done_t delayed 6 cycles, i.e. exactly 1 cycle after the last f8_wr_en.
- Reset mid-RUN:
  - Everything returns to IDLE/0 immediately.
  - In-flight delayed strobes are discarded; no partial done.
- fc3_start in the same cycle as fc3_done (back-to-back images) is accepted because the FSM is already IDLE.

Optional Feature:
Macro FC3_ARGMAX_EN.
- Defined:
  - On each f8_wr_en, fc3_dout (signed) is compared with the running max.
  - When f8_waddr==0 the running max and index load unconditionally.
  - Otherwise they update only on strictly greater, so ties keep the lowest index.
  - class_valid pulses together with fc3_done; class_id holds the winning index until the next fc3_done.
- Undefined: class_id and class_valid are tied to 0, no comparator logic, and fc3_dout is unused.

Decomposition:
- Shared package/header holds N_IN, N_OUT, the latency constants, the derived WR_LAT/CLR_LAT, and the one-hot state encodings IDLE=3'b001, RUN=3'b010, DONE=3'b100.
- One natural sub-module: pipe_delay (parameterised WIDTH, DEPTH shift register).
  - Instantiated for fc3_clr, for {f8_wr_en, f8_waddr}, and for fc3_done.

Test Plan:
- Start at cycle 0 -> f7_raddr 0..83 repeating 10 times from cycle 1; w7_raddr 0..839 consecutive; last address at cycle 840.
- fc3_clr high exactly at cycles 4+84k, k=0..9; no other clr pulses.
- f8_wr_en high at cycles 90+84k with f8_waddr=k, k=0..9; fc3_done single pulse at cycle 847.
- fc3_start pulses during RUN -> ignored; strobe timing identical to the clean run; new start at cycle 847 -> second run begins at cycle 848.
- Assert rst at cycle 300 -> all outputs 0 next sample; no f8_wr_en/fc3_done until a fresh start.
- FC3_ARGMAX_EN, scores {-5,3,7,7,-1,0,2,6,1,-8} -> class_id=2, class_valid coincident with fc3_done; all-negative scores select the maximum (e.g. -1 at index 4).
